// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl: boot/reload controller for the instruction memory.
// Streams host program words into consecutive memory words starting at 0,
// arbitrates the memory read address between the loader and the core's
// fetch path, and keeps the core stalled until a complete program is resident.
//
// Handshake: a host word is transferred on a rising clock edge exactly when
// load_valid and load_ready are both high in the cycle before that edge.
// load_ready depends only on state and load_start, never on load_valid.
// The host holds load_data/load_last stable while load_valid is high and
// load_ready is low.
module imem_load_ctrl #(
    parameter int DEPTH = 32,
    parameter int CW    = 6
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          load_start,
    input  logic          load_valid,
    input  logic [31:0]   load_data,
    input  logic          load_last,
    output logic          load_ready,
    input  logic [31:0]   fetch_addr,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_waddr,
    output logic [31:0]   mem_wdata,
    output logic          mem_we,
    output logic          cpu_stall,
    output logic          load_done,
    output logic          load_err,
    output logic          fetch_fault,
    output logic [CW-1:0] word_count,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    // Index of the final memory word and the saturated overflow count.
    localparam logic [CW-1:0] LAST_IDX  = CW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [31:0]   DEPTH_W32 = 32'(DEPTH);

    state_t state;
    logic   accept;
    logic   fetch_ok;

    // Handshake: restart wins over a word offered in the same cycle.
    always_comb begin
        load_ready = (state == S_LOAD) && !load_start;
        accept     = load_valid && load_ready;
    end

    // Write port: the accepted word lands at the slot word_count points at.
    always_comb begin
        mem_we    = accept;
        mem_waddr = 32'(word_count);
        mem_wdata = accept ? load_data : 32'd0;
    end

    // Read address mux: the core fetches in RUN, the loader reads back otherwise.
    always_comb begin
        fetch_ok    = (fetch_addr < DEPTH_W32);
        mem_addr    = 32'(word_count);
        fetch_fault = 1'b0;
        if (state == S_RUN) begin
            mem_addr    = fetch_ok ? fetch_addr : 32'd0;
            fetch_fault = !fetch_ok;
        end
    end

    // Status outputs decoded from the state alone.
    always_comb begin
        cpu_stall = (state != S_RUN);
        load_done = (state == S_RUN);
        load_err  = (state == S_ERR);
        dbg_state = state;
    end

    // Controller FSM and word counter; load_start restarts from every state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            word_count <= '0;
        end else if (load_start) begin
            state      <= S_LOAD;
            word_count <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (accept) begin
                        if (load_last) begin
                            state      <= S_RUN;
                            word_count <= word_count + CW'(1);
                        end else if (word_count == LAST_IDX) begin
                            // Final slot written without load_last: overflow.
                            state      <= S_ERR;
                            word_count <= FULL_CNT;
                        end else begin
                            word_count <= word_count + CW'(1);
                        end
                    end
                end
                S_IDLE:  state <= S_IDLE;
                S_RUN:   state <= S_RUN;
                S_ERR:   state <= S_ERR;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Bench for imem_load_ctrl: directed vector table, hand-written multi-cycle
// sequences, then randomized traffic against a behavioural model.
module tb_imem_load_ctrl;
    localparam int DEPTH = 32;
    localparam int CW    = 6;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset_n;
    logic          load_start, load_valid, load_last;
    logic [31:0]   load_data, fetch_addr;
    logic          load_ready, mem_we, cpu_stall, load_done, load_err, fetch_fault;
    logic [31:0]   mem_addr, mem_waddr, mem_wdata;
    logic [CW-1:0] word_count;
    logic [1:0]    dbg_state;

    imem_load_ctrl #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clock(clock), .reset_n(reset_n),
        .load_start(load_start), .load_valid(load_valid),
        .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
        .fetch_addr(fetch_addr), .mem_addr(mem_addr), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .cpu_stall(cpu_stall),
        .load_done(load_done), .load_err(load_err), .fetch_fault(fetch_fault),
        .word_count(word_count), .dbg_state(dbg_state)
    );

    int checks   = 0;
    int failures = 0;
    logic [37:0] exp_q[$];   // {waddr[5:0], wdata[31:0]}

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic e_ready, input logic e_we,
                           input logic [31:0] e_waddr, input logic [31:0] e_wdata,
                           input logic e_stall, input logic e_done, input logic e_err,
                           input logic e_fault, input logic [31:0] e_maddr,
                           input logic [31:0] e_wc);
        chk({tag, ".load_ready"},  32'(load_ready),  32'(e_ready));
        chk({tag, ".mem_we"},      32'(mem_we),      32'(e_we));
        chk({tag, ".mem_waddr"},   mem_waddr,        e_waddr);
        chk({tag, ".mem_wdata"},   mem_wdata,        e_wdata);
        chk({tag, ".cpu_stall"},   32'(cpu_stall),   32'(e_stall));
        chk({tag, ".load_done"},   32'(load_done),   32'(e_done));
        chk({tag, ".load_err"},    32'(load_err),    32'(e_err));
        chk({tag, ".fetch_fault"}, 32'(fetch_fault), 32'(e_fault));
        chk({tag, ".mem_addr"},    mem_addr,         e_maddr);
        chk({tag, ".word_count"},  32'(word_count),  e_wc);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic s, input logic v, input logic l,
                         input logic [31:0] d, input logic [31:0] f);
        load_start = s; load_valid = v; load_last = l; load_data = d; fetch_addr = f;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        drive(0, 0, 0, 0, 0);
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic s, v, l; logic [31:0] d, f;
        logic e_ready, e_we; logic [31:0] e_waddr, e_wdata;
        logic e_stall, e_done, e_err, e_fault; logic [31:0] e_maddr, e_wc;
    } vec_t;

    vec_t vecs[13];

    // ---------------- behavioural reference model ----------------
    bit m_loading, m_running, m_overflow;
    int m_count;

    initial begin
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        repeat (2) @(posedge clock);
        #1;
        chk_out("reset", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        reset_n = 1'b1;

        //           s  v  l  data           fetch  rdy we waddr wdata         stl dn er flt maddr wc
        vecs[0]  = '{0, 1, 0, 32'h11111111,  0,     0,  0, 0,    0,            1,  0, 0, 0,  0,    0};
        vecs[1]  = '{1, 1, 0, 32'h22222222,  0,     0,  0, 0,    0,            1,  0, 0, 0,  0,    0};
        vecs[2]  = '{0, 1, 0, 32'h00A200B3,  0,     1,  1, 0,    32'h00A200B3, 1,  0, 0, 0,  0,    0};
        vecs[3]  = '{0, 1, 0, 32'h40120133,  0,     1,  1, 1,    32'h40120133, 1,  0, 0, 0,  1,    1};
        vecs[4]  = '{0, 1, 1, 32'h00000013,  0,     1,  1, 2,    32'h00000013, 1,  0, 0, 0,  2,    2};
        vecs[5]  = '{0, 1, 0, 32'h33333333,  1,     0,  0, 3,    0,            0,  1, 0, 0,  1,    3};
        vecs[6]  = '{0, 0, 0, 0,             40,    0,  0, 3,    0,            0,  1, 0, 1,  0,    3};
        vecs[7]  = '{0, 0, 0, 0,             31,    0,  0, 3,    0,            0,  1, 0, 0,  31,   3};
        vecs[8]  = '{0, 0, 0, 0,             32,    0,  0, 3,    0,            0,  1, 0, 1,  0,    3};
        vecs[9]  = '{1, 0, 0, 0,             2,     0,  0, 3,    0,            0,  1, 0, 0,  2,    3};
        vecs[10] = '{0, 0, 0, 0,             40,    1,  0, 0,    0,            1,  0, 0, 0,  0,    0};
        vecs[11] = '{0, 1, 1, 32'hDEADBEEF,  40,    1,  1, 0,    32'hDEADBEEF, 1,  0, 0, 0,  0,    0};
        vecs[12] = '{0, 0, 0, 0,             0,     0,  0, 1,    0,            0,  1, 0, 0,  0,    1};

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].s, vecs[i].v, vecs[i].l, vecs[i].d, vecs[i].f);
            @(negedge clock);
            chk_out($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_we, vecs[i].e_waddr,
                    vecs[i].e_wdata, vecs[i].e_stall, vecs[i].e_done, vecs[i].e_err,
                    vecs[i].e_fault, vecs[i].e_maddr, vecs[i].e_wc);
            next_cycle();
        end

        // ---- restart mid-load at word_count=5 with a word offered ----
        drive(1, 0, 0, 0, 0);
        next_cycle();
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 0, 32'h100 + 32'(i), 0);
            @(negedge clock);
            chk($sformatf("restart.we%0d", i), 32'(mem_we), 1);
            chk($sformatf("restart.waddr%0d", i), mem_waddr, 32'(i));
            next_cycle();
        end
        drive(1, 1, 0, 32'h0BAD0BAD, 0);
        @(negedge clock);
        chk("restart.pulse.we", 32'(mem_we), 0);
        chk("restart.pulse.wc", 32'(word_count), 5);
        next_cycle();
        drive(0, 1, 0, 32'h00001234, 0);
        @(negedge clock);
        chk("restart.after.wc", 32'(word_count), 0);
        chk("restart.after.we", 32'(mem_we), 1);
        chk("restart.after.waddr", mem_waddr, 0);
        chk("restart.after.wdata", mem_wdata, 32'h00001234);
        next_cycle();

        // ---- overflow: 32 words without load_last ----
        drive(1, 0, 0, 0, 0);
        next_cycle();
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 1, 0, 32'h1000 + 32'(i), 0);
            @(negedge clock);
            chk($sformatf("ovf.we%0d", i), 32'(mem_we), 1);
            chk($sformatf("ovf.waddr%0d", i), mem_waddr, 32'(i));
            next_cycle();
        end
        drive(0, 1, 1, 32'hFFFF0000, 0);
        @(negedge clock);
        chk_out("ovf.err", 0, 0, 32, 0, 1, 0, 1, 0, 32, 32);
        next_cycle();
        drive(0, 1, 0, 32'hFFFF0001, 50);
        @(negedge clock);
        chk_out("ovf.hold", 0, 0, 32, 0, 1, 0, 1, 0, 32, 32);
        next_cycle();

        // ---- leave ERR, 1-word load, then restart from RUN ----
        drive(1, 0, 0, 0, 0);
        next_cycle();
        drive(0, 1, 1, 32'h00000055, 0);
        @(negedge clock);
        chk_out("err_exit.word", 1, 1, 0, 32'h55, 1, 0, 0, 0, 0, 0);
        next_cycle();
        drive(1, 0, 0, 0, 3);
        @(negedge clock);
        chk_out("run_restart.pulse", 0, 0, 1, 0, 0, 1, 0, 0, 3, 1);
        next_cycle();
        drive(0, 0, 0, 0, 3);
        @(negedge clock);
        chk_out("run_restart.next", 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        next_cycle();
        drive(0, 1, 1, 32'h00000077, 3);
        @(negedge clock);
        chk_out("run_restart.word", 1, 1, 0, 32'h77, 1, 0, 0, 0, 0, 0);
        next_cycle();
        drive(0, 0, 0, 0, 3);
        @(negedge clock);
        chk_out("run_restart.run", 0, 0, 1, 0, 0, 1, 0, 0, 3, 1);
        next_cycle();

        // ---- asynchronous reset between edges mid-load ----
        drive(1, 0, 0, 0, 0);
        next_cycle();
        drive(0, 1, 0, 32'h000000AA, 0);
        next_cycle();
        next_cycle();
        drive(0, 1, 0, 32'h000000AB, 0);
        @(negedge clock);
        chk("areset.pre.wc", 32'(word_count), 2);
        #2;
        reset_n = 1'b0;
        #1;
        chk_out("areset.now", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        @(posedge clock);
        #3;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk_out($sformatf("areset.after%0d", i), 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
            next_cycle();
        end

        // ---- randomized traffic against the behavioural model ----
        apply_reset();
        m_loading = 0; m_running = 0; m_overflow = 0; m_count = 0;
        for (int n = 0; n < 3000; n++) begin
            logic s, v, l, rdy, acc;
            logic [31:0] d, f, e_maddr;
            s = ($urandom_range(0, 19) == 0);
            v = ($urandom_range(0, 3) != 0);
            l = ($urandom_range(0, 29) == 0);
            d = $urandom;
            f = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 47));
            rdy = m_loading && !s;
            acc = rdy && v;
            if (!m_running) e_maddr = 32'(m_count);
            else if (f < DEPTH) e_maddr = f;
            else e_maddr = 0;
            drive(s, v, l, d, f);
            @(negedge clock);
            chk_out($sformatf("rand%0d", n), rdy, acc, 32'(m_count), acc ? d : 32'd0,
                    !m_running, m_running, m_overflow, m_running && (f >= DEPTH),
                    e_maddr, 32'(m_count));
            if (acc) exp_q.push_back({6'(m_count), d});
            if (mem_we) begin
                if (exp_q.size() == 0) begin
                    chk($sformatf("rand%0d.unexpected_write", n), 32'(mem_we), 0);
                end else begin
                    logic [37:0] e;
                    e = exp_q.pop_front();
                    chk($sformatf("rand%0d.sb_addr", n), mem_waddr, 32'(e[37:32]));
                    chk($sformatf("rand%0d.sb_data", n), mem_wdata, e[31:0]);
                end
            end
            // model update: restart beats everything, then accepted word
            if (s) begin
                m_loading = 1; m_running = 0; m_overflow = 0; m_count = 0;
            end else if (acc) begin
                m_count++;
                if (l) begin
                    m_loading = 0; m_running = 1;
                end else if (m_count == DEPTH) begin
                    m_loading = 0; m_overflow = 1;
                end
            end
            next_cycle();
        end
        chk("scoreboard.drained", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
